// File: rtl/clock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// clock_ctrl_pkg : shared widths, limits, state codes and field wrap helpers
// Rev 1.0
// ============================================================================
package clock_ctrl_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

    typedef enum logic [2:0] {
        RUN         = 3'd0,
        SET_HOUR    = 3'd1,
        SET_MIN     = 3'd2,
        SET_AL_HOUR = 3'd3,
        SET_AL_MIN  = 3'd4
    } state_t;

    // Out-of-range values (e.g. a captured 31) also wrap to zero.
    function automatic logic [HOUR_W-1:0] inc_hour(input logic [HOUR_W-1:0] h);
        return (h >= MAX_HOUR) ? '0 : h + HOUR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] inc_min(input logic [MIN_W-1:0] m);
        return (m >= MAX_MIN) ? '0 : m + MIN_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_ctrl_prescaler.sv
`default_nettype none
// ============================================================================
// clock_ctrl_prescaler : 1 Hz tick divider and set-mode blink divider
// Rev 1.0
// ============================================================================
module clock_ctrl_prescaler #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic run,
    input  logic clear,
    input  logic blink_en,
    input  logic blink_start,
    output logic tick,
    output logic blink
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [TW-1:0] C_TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [TW-1:0] r_tick_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;

    wire w_tick_last = (r_tick_cnt == C_TICK_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_tick_cnt <= '0;
        end else if (clear || !run || w_tick_last) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    assign tick = run & ~clear & w_tick_last;

    // Blink restarts high on every entry into editing.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (!blink_en) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (blink_start) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (r_blink_cnt == C_BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign blink = r_blink;

endmodule
`default_nettype wire

// File: rtl/clock_set_controller.sv
`default_nettype none
// ============================================================================
// clock_set_controller : run/set-time sequencer for the HH:MM:SS timekeeper
// Optional alarm editing and indication enabled by ALARM_SUPPORT_EN.
// Rev 1.0
// ============================================================================
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    output logic              tick_1hz,
    output logic              load,
    output logic [HOUR_W-1:0] load_hour,
    output logic [MIN_W-1:0]  load_min,
    output logic [2:0]        mode,
    output logic              blink
`ifdef ALARM_SUPPORT_EN
    ,
    output logic              alarm_on,
    input  logic              alarm_ack
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic              r_mode_q;
    logic              r_inc_q;
    logic [HOUR_W-1:0] r_shadow_h;
    logic [MIN_W-1:0]  r_shadow_m;
    logic              r_load;
    logic [HOUR_W-1:0] r_load_hour;
    logic [MIN_W-1:0]  r_load_min;

    wire w_mode_edge = btn_mode & ~r_mode_q;
    wire w_inc_raw   = btn_inc & ~r_inc_q;
    wire w_inc_edge  = w_inc_raw & ~w_mode_edge;
    wire w_leave_min = (r_state == SET_MIN) & w_mode_edge;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_mode_edge) begin
            case (r_state)
                RUN:         w_next = SET_HOUR;
                SET_HOUR:    w_next = SET_MIN;
`ifdef ALARM_SUPPORT_EN
                SET_MIN:     w_next = SET_AL_HOUR;
                SET_AL_HOUR: w_next = SET_AL_MIN;
                SET_AL_MIN:  w_next = RUN;
`else
                SET_MIN:     w_next = RUN;
`endif
                default:     w_next = RUN;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_mode_q    <= 1'b0;
            r_inc_q     <= 1'b0;
            r_shadow_h  <= '0;
            r_shadow_m  <= '0;
            r_load      <= 1'b0;
            r_load_hour <= '0;
            r_load_min  <= '0;
        end else begin
            r_mode_q <= btn_mode;
            r_inc_q  <= btn_inc;
            r_load   <= w_leave_min;
            if ((r_state == RUN) && w_mode_edge) begin
                r_shadow_h <= cur_hour;
                r_shadow_m <= cur_min;
            end
            if ((r_state == SET_HOUR) && w_inc_edge) begin
                r_shadow_h <= inc_hour(r_shadow_h);
            end
            if ((r_state == SET_MIN) && w_inc_edge) begin
                r_shadow_m <= inc_min(r_shadow_m);
            end
            if (w_leave_min) begin
                r_load_hour <= r_shadow_h;
                r_load_min  <= r_shadow_m;
            end
        end
    end

    clock_ctrl_prescaler #(
        .TICK_DIV  (TICK_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) u_prescaler (
        .Clock       (Clock),
        .Reset       (Reset),
        .run         (r_state == RUN),
        .clear       (w_leave_min),
        .blink_en    (w_next != RUN),
        .blink_start ((r_state == RUN) && (w_next != RUN)),
        .tick        (tick_1hz),
        .blink       (blink)
    );

    assign load      = r_load;
    assign load_hour = r_load_hour;
    assign load_min  = r_load_min;
    assign mode      = r_state;

`ifdef ALARM_SUPPORT_EN
    logic [HOUR_W-1:0] r_al_h;
    logic [MIN_W-1:0]  r_al_m;
    logic [HOUR_W-1:0] r_alarm_h;
    logic [MIN_W-1:0]  r_alarm_m;
    logic              r_match_q;
    logic              r_alarm_on;

    wire w_match     = (cur_hour == r_alarm_h) && (cur_min == r_alarm_m);
    wire w_alarm_set = (r_state == RUN) & w_match & ~r_match_q;
    wire w_alarm_clr = alarm_ack | w_mode_edge | w_inc_raw;

    // Edits happen on a working copy; the stored alarm changes only on exit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_al_h     <= '0;
            r_al_m     <= '0;
            r_alarm_h  <= '0;
            r_alarm_m  <= '0;
            r_match_q  <= 1'b0;
            r_alarm_on <= 1'b0;
        end else begin
            r_match_q <= w_match;
            if (w_leave_min) begin
                r_al_h <= r_alarm_h;
                r_al_m <= r_alarm_m;
            end
            if ((r_state == SET_AL_HOUR) && w_inc_edge) begin
                r_al_h <= inc_hour(r_al_h);
            end
            if ((r_state == SET_AL_MIN) && w_inc_edge) begin
                r_al_m <= inc_min(r_al_m);
            end
            if ((r_state == SET_AL_MIN) && w_mode_edge) begin
                r_alarm_h <= r_al_h;
                r_alarm_m <= r_al_m;
            end
            if (w_alarm_clr) begin
                r_alarm_on <= 1'b0;
            end else if (w_alarm_set) begin
                r_alarm_on <= 1'b1;
            end
        end
    end

    assign alarm_on = r_alarm_on;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clock_set_controller.sv
`default_nettype none
// ============================================================================
// tb_clock_set_controller : scoreboard bench for clock_set_controller
// Rev 1.0
// ============================================================================
module tb_clock_set_controller;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [5:0] cur_min = '0;
    logic       tick_1hz;
    logic       load;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [2:0] mode;
    logic       blink;
`ifdef ALARM_SUPPORT_EN
    logic       alarm_on;
    logic       alarm_ack = 1'b0;
`endif

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        tick_chk = 1'b0;
    logic [10:0] exp_load[$];
    int          exp_tick[$];

    clock_set_controller #(
        .TICK_DIV  (4),
        .BLINK_DIV (2)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .tick_1hz  (tick_1hz),
        .load      (load),
        .load_hour (load_hour),
        .load_min  (load_min),
        .mode      (mode),
        .blink     (blink)
`ifdef ALARM_SUPPORT_EN
        ,
        .alarm_on  (alarm_on),
        .alarm_ack (alarm_ack)
`endif
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a load or tick.
    always @(negedge Clock) begin
        if (!Reset) begin
            if (load) begin
                checks++;
                if (exp_load.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_load got=%0d:%0d exp=none", load_hour, load_min);
                end else begin
                    logic [10:0] e;
                    e = exp_load.pop_front();
                    if ({load_hour, load_min} !== e) begin
                        failures++;
                        $display("FAIL load_value got=%0d:%0d exp=%0d:%0d",
                                 load_hour, load_min, e[10:6], e[5:0]);
                    end
                end
            end
            if (tick_1hz && mode != 3'd0) begin
                checks++;
                failures++;
                $display("FAIL tick_in_set got=mode%0d exp=no_tick", mode);
            end else if (tick_1hz && tick_chk) begin
                checks++;
                if (exp_tick.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_tick got=cyc%0d exp=none", cyc);
                end else begin
                    int t;
                    t = exp_tick.pop_front();
                    if (t != cyc) begin
                        failures++;
                        $display("FAIL tick_cycle got=%0d exp=%0d", cyc, t);
                    end
                end
            end
        end
    end

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        @(negedge Clock);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        @(negedge Clock);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge Clock);
    endtask

    initial begin
        int base;

        // 1. reset state, then free-running ticks every 4th cycle
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        base  = cyc;
        check("rst_mode", mode, 0);
        check("rst_blink", blink, 0);
        check("rst_tick", tick_1hz, 0);
        check("rst_load", load, 0);
        check("rst_load_hour", load_hour, 0);
        check("rst_load_min", load_min, 0);
        for (int k = 0; k < 5; k++) exp_tick.push_back(base + 3 + 4 * k);
        tick_chk = 1'b1;
        wait_until(base + 10);
        check("run_mode", mode, 0);
        check("run_blink", blink, 0);
        wait_until(base + 20);
        tick_chk = 1'b0;
        check("tick_q_empty_1", exp_tick.size(), 0);

        // 2. 10:30 -> three hour incs, two minute incs -> 13:32
        cur_hour = 5'd10;
        cur_min  = 6'd30;
        press(1'b1, 1'b0);
        check("set_hour_mode", mode, 1);
        check("set_entry_blink", blink, 1);
        repeat (3) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("set_min_mode", mode, 2);
        repeat (2) press(1'b0, 1'b1);
        exp_load.push_back({5'd13, 6'd32});
        base = cyc;
        exp_tick.push_back(base + 4);
        exp_tick.push_back(base + 8);
        tick_chk = 1'b1;
        press(1'b1, 1'b0);
        check("back_to_run", mode, 0);
        check("run_blink_off", blink, 0);
        wait_until(base + 9);
        tick_chk = 1'b0;
        check("tick_q_empty_2", exp_tick.size(), 0);
        check("load_q_empty_2", exp_load.size(), 0);

        // 3. 23:59 wraps to 00:00
        cur_hour = 5'd23;
        cur_min  = 6'd59;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        exp_load.push_back({5'd0, 6'd0});
        press(1'b1, 1'b0);
        check("load_q_empty_3", exp_load.size(), 0);

        // 4. held inc counts once: 05:00 -> 06:00
        cur_hour = 5'd5;
        cur_min  = 6'd0;
        press(1'b1, 1'b0);
        btn_inc = 1'b1;
        repeat (10) @(negedge Clock);
        btn_inc = 1'b0;
        @(negedge Clock);
        press(1'b1, 1'b0);
        exp_load.push_back({5'd6, 6'd0});
        press(1'b1, 1'b0);
        check("load_q_empty_4", exp_load.size(), 0);

        // 5. simultaneous mode+inc: mode wins, 08:15 unchanged
        cur_hour = 5'd8;
        cur_min  = 6'd15;
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("mode_wins", mode, 2);
        exp_load.push_back({5'd8, 6'd15});
        press(1'b1, 1'b0);
        check("load_q_empty_5", exp_load.size(), 0);

        // 6. async reset during SET_MIN discards the edit
        cur_hour = 5'd12;
        cur_min  = 6'd0;
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        check("pre_rst_mode", mode, 2);
        #1 Reset = 1'b1;
        #1;
        check("async_rst_mode", mode, 0);
        check("async_rst_blink", blink, 0);
        check("async_rst_load_hour", load_hour, 0);
        check("async_rst_load_min", load_min, 0);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        repeat (6) @(negedge Clock);
        check("post_rst_mode", mode, 0);
        check("load_q_empty_6", exp_load.size(), 0);

`ifdef ALARM_SUPPORT_EN
        // 7. set alarm 07:05, then match raises alarm_on, ack clears it
        cur_hour = 5'd1;
        cur_min  = 6'd0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        exp_load.push_back({5'd1, 6'd0});
        press(1'b1, 1'b0);
        check("al_hour_mode", mode, 3);
        repeat (7) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("al_min_mode", mode, 4);
        repeat (5) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("al_back_run", mode, 0);
        check("alarm_idle", alarm_on, 0);
        cur_hour = 5'd7;
        cur_min  = 6'd5;
        repeat (2) @(negedge Clock);
        check("alarm_set", alarm_on, 1);
        alarm_ack = 1'b1;
        @(negedge Clock);
        alarm_ack = 1'b0;
        check("alarm_ack_clear", alarm_on, 0);
        check("load_q_empty_7", exp_load.size(), 0);
`endif

        @(negedge Clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
